// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial deserializer.
package deser_pkg;

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

  localparam int MAX_WIDTH = 64;

  function automatic int cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/deser_bit_cnt.sv
// Modulo-WIDTH bit counter with enable and synchronous clear; flags the last bit of a word.
module deser_bit_cnt
  import deser_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_count,
  output logic          o_last
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      // Explicit wrap keeps non-power-of-2 widths on the modulo-WIDTH sequence.
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == LAST);

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with a one-word valid/ready holding buffer and sticky overrun.
module serial_deser
  import deser_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit LSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  input  logic             resync,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             word_done,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_next;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_word_done;
  logic             r_overrun;
  buf_state_t       r_state;
  logic             w_last;
  logic             w_complete;
  logic             w_drop;

  deser_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (en),
    .i_clr   (resync),
    .o_count (bit_cnt),
    .o_last  (w_last)
  );

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_sreg_next = {si, r_sreg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_sreg_next = {r_sreg[WIDTH-2:0], si};
    end
  endgenerate

  // The loaded word is the shifted value, so it includes the bit sampled on the completing edge.
  assign w_complete = en && w_last && !resync;
  assign w_drop     = w_complete && (r_state == BUF_FULL) && !out_ready;

  always_ff @(posedge clk) begin
    if (rst || resync) begin
      r_sreg <= '0;
    end else if (en) begin
      r_sreg <= w_sreg_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BUF_EMPTY;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_word_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_word_done <= w_complete;
      r_overrun   <= w_drop || (r_overrun && !ovr_clr);
      case (r_state)
        BUF_EMPTY: begin
          if (w_complete) begin
            r_out_data  <= w_sreg_next;
            r_out_valid <= 1'b1;
            r_state     <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (out_ready) begin
            if (w_complete) begin
              r_out_data <= w_sreg_next;
            end else begin
              r_out_valid <= 1'b0;
              r_state     <= BUF_EMPTY;
            end
          end
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign word_done = r_word_done;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_deser.sv
// Randomized bench for serial_deser: three instances checked every cycle against a word-level model.
module tb_serial_deser;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, si = 1'b0, resync = 1'b0, ovr_clr = 1'b0, out_ready = 1'b0;

  logic [7:0] d0_data, d1_data;
  logic [4:0] d2_data;
  logic [2:0] d0_cnt, d1_cnt, d2_cnt;
  logic d0_valid, d1_valid, d2_valid, d0_done, d1_done, d2_done, d0_ovr, d1_ovr, d2_ovr;

  serial_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_w8_lsb (
    .clk(clk), .rst(rst), .en(en), .si(si), .resync(resync), .ovr_clr(ovr_clr),
    .out_data(d0_data), .out_valid(d0_valid), .out_ready(out_ready),
    .word_done(d0_done), .bit_cnt(d0_cnt), .overrun(d0_ovr));

  serial_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_w8_msb (
    .clk(clk), .rst(rst), .en(en), .si(si), .resync(resync), .ovr_clr(ovr_clr),
    .out_data(d1_data), .out_valid(d1_valid), .out_ready(out_ready),
    .word_done(d1_done), .bit_cnt(d1_cnt), .overrun(d1_ovr));

  serial_deser #(.WIDTH(5), .LSB_FIRST(1'b1)) dut_w5_lsb (
    .clk(clk), .rst(rst), .en(en), .si(si), .resync(resync), .ovr_clr(ovr_clr),
    .out_data(d2_data), .out_valid(d2_valid), .out_ready(out_ready),
    .word_done(d2_done), .bit_cnt(d2_cnt), .overrun(d2_ovr));

  logic [63:0] a_data [N];
  logic [31:0] a_cnt  [N];
  logic        a_valid[N], a_done[N], a_ovr[N];

  assign a_data[0] = 64'(d0_data);  assign a_data[1] = 64'(d1_data);  assign a_data[2] = 64'(d2_data);
  assign a_cnt[0]  = 32'(d0_cnt);   assign a_cnt[1]  = 32'(d1_cnt);   assign a_cnt[2]  = 32'(d2_cnt);
  assign a_valid[0] = d0_valid;     assign a_valid[1] = d1_valid;     assign a_valid[2] = d2_valid;
  assign a_done[0]  = d0_done;      assign a_done[1]  = d1_done;      assign a_done[2]  = d2_done;
  assign a_ovr[0]   = d0_ovr;       assign a_ovr[1]   = d1_ovr;       assign a_ovr[2]   = d2_ovr;

  // Word-level model: bits are kept in arrival order and placed into the word only when it completes.
  int          m_width[N] = '{8, 8, 5};
  bit          m_lsb  [N] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] m_acc  [N];
  int          m_cnt  [N];
  logic [63:0] m_data [N];
  logic        m_valid[N], m_done[N], m_ovr[N];

  int n_vec = 0;
  int n_err = 0;

  task automatic model_edge(input int k);
    logic [63:0] word;
    bit complete, drop;
    complete = 1'b0;
    drop     = 1'b0;
    word     = '0;
    if (rst) begin
      m_cnt[k] = 0; m_data[k] = '0; m_valid[k] = 1'b0; m_done[k] = 1'b0; m_ovr[k] = 1'b0;
    end else begin
      if (resync) begin
        m_cnt[k] = 0;
      end else if (en) begin
        m_acc[k][m_cnt[k]] = si;
        m_cnt[k]++;
        if (m_cnt[k] == m_width[k]) begin
          complete = 1'b1;
          for (int i = 0; i < m_width[k]; i++) begin
            if (m_lsb[k]) word[i] = m_acc[k][i];
            else          word[m_width[k]-1-i] = m_acc[k][i];
          end
          m_cnt[k] = 0;
        end
      end
      if (complete) begin
        if (!m_valid[k] || out_ready) begin
          m_valid[k] = 1'b1;
          m_data[k]  = word;
        end else begin
          drop = 1'b1;
        end
      end else if (m_valid[k] && out_ready) begin
        m_valid[k] = 1'b0;
      end
      m_ovr[k]  = drop || (m_ovr[k] && !ovr_clr);
      m_done[k] = complete;
    end
  endtask

  // One clock edge: advance the model, then compare every instance just after the edge.
  task automatic step();
    @(posedge clk);
    for (int k = 0; k < N; k++) model_edge(k);
    #1;
    for (int k = 0; k < N; k++) begin
      n_vec += 5;
      if (a_data[k] !== m_data[k]) begin
        n_err++; $display("FAIL dut%0d out_data: got %h want %h", k, a_data[k], m_data[k]);
      end
      if (a_valid[k] !== m_valid[k]) begin
        n_err++; $display("FAIL dut%0d out_valid: got %b want %b", k, a_valid[k], m_valid[k]);
      end
      if (a_done[k] !== m_done[k]) begin
        n_err++; $display("FAIL dut%0d word_done: got %b want %b", k, a_done[k], m_done[k]);
      end
      if (a_cnt[k] !== 32'(m_cnt[k])) begin
        n_err++; $display("FAIL dut%0d bit_cnt: got %0d want %0d", k, a_cnt[k], m_cnt[k]);
      end
      if (a_ovr[k] !== m_ovr[k]) begin
        n_err++; $display("FAIL dut%0d overrun: got %b want %b", k, a_ovr[k], m_ovr[k]);
      end
    end
  endtask

  // Send seq[0] first, optionally with random idle (en=0) cycles before each bit; leaves en=0.
  task automatic send_seq(input logic [63:0] seq, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      en = 1'b0;
      si = 1'($urandom);
      for (int g = 0; g < int'($urandom_range(max_gap, 0)); g++) step();
      en = 1'b1;
      si = seq[i];
      step();
    end
    en = 1'b0;
    si = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; resync = 1'b0; ovr_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    n_vec++;
    if ({d0_data, d0_valid, d0_done, d0_cnt, d0_ovr} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0", {d0_data, d0_valid, d0_done, d0_cnt, d0_ovr});
    end
  endtask

  task automatic test_lsb_first();
    do_reset();
    out_ready = 1'b1;
    send_seq(64'hA5, 8, 0);
    expect_bit("lsb_valid_latency", d0_valid, 1'b1);
    expect_bit("lsb_word_done", d0_done, 1'b1);
    n_vec++;
    if (d0_data !== 8'hA5) begin
      n_err++; $display("FAIL lsb_data: got %h want a5", d0_data);
    end
    step();
    expect_bit("lsb_word_done_single", d0_done, 1'b0);
    expect_bit("lsb_consumed", d0_valid, 1'b0);
  endtask

  task automatic test_msb_first();
    do_reset();
    out_ready = 1'b0;
    send_seq(64'h4D, 8, 3);  // arrival order 1,0,1,1,0,0,1,0
    n_vec++;
    if (d1_data !== 8'hB2) begin
      n_err++; $display("FAIL msb_data: got %h want b2", d1_data);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    send_seq(64'h3C, 8, 1);
    send_seq(64'hFF, 8, 1);
    n_vec++;
    if (d0_data !== 8'h3C) begin
      n_err++; $display("FAIL overrun_hold: got %h want 3c", d0_data);
    end
    expect_bit("overrun_set", d0_ovr, 1'b1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    expect_bit("overrun_clear", d0_ovr, 1'b0);
    out_ready = 1'b1;
    step();
    expect_bit("overrun_drain", d0_valid, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    send_seq(64'h11, 8, 0);
    send_seq(64'h22, 7, 1);
    en = 1'b1; si = 1'b0; out_ready = 1'b1;  // bit 7 of 0x22 completes on the handshake edge
    step();
    en = 1'b0; out_ready = 1'b0;
    expect_bit("b2b_valid", d0_valid, 1'b1);
    expect_bit("b2b_no_overrun", d0_ovr, 1'b0);
    n_vec++;
    if (d0_data !== 8'h22) begin
      n_err++; $display("FAIL b2b_data: got %h want 22", d0_data);
    end
  endtask

  task automatic test_resync_w5();
    do_reset();
    out_ready = 1'b1;
    send_seq(64'($urandom), 3, 0);
    resync = 1'b1; en = 1'b1; si = 1'b1;
    step();
    resync = 1'b0; en = 1'b0;
    n_vec++;
    if (d2_cnt !== 3'd0) begin
      n_err++; $display("FAIL resync_cnt: got %0d want 0", d2_cnt);
    end
    send_seq(64'h16, 4, 1);
    n_vec++;
    if (d2_cnt !== 3'd4) begin
      n_err++; $display("FAIL w5_cnt_last: got %0d want 4", d2_cnt);
    end
    en = 1'b1; si = 1'b1;
    step();
    en = 1'b0;
    n_vec++;
    if (d2_cnt !== 3'd0 || d2_data !== 5'h16) begin
      n_err++; $display("FAIL w5_wrap_data: got cnt %0d data %h want cnt 0 data 16", d2_cnt, d2_data);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    do_reset();
    out_ready = 1'b0;
    send_seq(64'($urandom), 8, 0);
    send_seq(64'($urandom), 5, 0);
    rst = 1'b1; en = 1'b1; si = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    n_vec++;
    if ({d0_data, d0_valid, d0_done, d0_cnt, d0_ovr} !== '0) begin
      n_err++; $display("FAIL mid_reset: got %h want 0", {d0_data, d0_valid, d0_done, d0_cnt, d0_ovr});
    end
    w = 64'($urandom);
    out_ready = 1'b1;
    send_seq(w, 8, 1);
    n_vec++;
    if (d0_data !== w[7:0]) begin
      n_err++; $display("FAIL post_reset_word: got %h want %h", d0_data, w[7:0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(63, 0) == 0);
      en        = ($urandom_range(3, 0) != 0);
      si        = 1'($urandom);
      resync    = ($urandom_range(23, 0) == 0);
      ovr_clr   = ($urandom_range(7, 0) == 0);
      out_ready = ($urandom_range(2, 0) == 0);
      step();
    end
    rst = 1'b0; en = 1'b0; resync = 1'b0; ovr_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_overrun();
    test_back_to_back();
    test_resync_w5();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
Parametrised serial-to-parallel deserializer that collects WIDTH serial bits into a word and presents it through a valid/ready output buffer. It replaces the fixed 8-bit shift-register/counter pair. It adds configurable bit order, a mid-word resync input, a one-word output holding buffer with backpressure, and sticky overrun detection. It sits between a bit-serial receive front end and any word-wide consumer.

Parameters:
WIDTH, 8, bits per word; legal range 2..64.
LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit WIDTH-1.
CW, $clog2(WIDTH), bit-counter width; derived, never overridden.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
en  in  1  bit strobe; si sampled on an edge only when en=1
si  in  1  serial data bit
resync  in  1  synchronous abort of the partially assembled word
ovr_clr  in  1  clears sticky overrun flag
out_data  out  WIDTH  assembled word (holding register)
out_valid  out  1  holding register contains an unconsumed word
out_ready  in  1  consumer accepts word when out_valid && out_ready at an edge
word_done  out  1  one-cycle pulse: a word completed on the previous edge
bit_cnt  out  CW  number of bits of the current word already received
overrun  out  1  sticky: a completed word was dropped

Behaviour:
- Reset is synchronous and active-high on clk. On rst: bit_cnt=0, shift register=0, out_data=0, out_valid=0, word_done=0, overrun=0. rst overrides all other inputs, including a word completing on the same edge.
- Shift, LSB_FIRST=1: sreg <= {si, sreg[WIDTH-1:1]}.
- Shift, LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], si}.
- Counter: on en=1, bit_cnt increments. It wraps WIDTH-1 -> 0 for any WIDTH, including non-powers of 2.
- Completion: an edge with en=1 and bit_cnt==WIDTH-1. The word includes the si sampled on that edge.
- Output buffer FSM, two states:
  - EMPTY: out_valid=0. On completion, load out_data, go to FULL. out_valid is high the cycle after the final bit's edge (latency 1).
  - FULL: out_valid=1 and out_data is held stable.
    - out_ready=1 with no completion: go to EMPTY.
    - out_ready=1 with completion on the same edge: load the new word and stay FULL. No bubble, no overrun.
    - out_ready=0 with completion: drop the new word, keep the old out_data, set overrun.
- word_done pulses one cycle after every completion, including dropped words.
- resync=1: bit_cnt<=0 and sreg<=0 on that edge; the sampled bit is discarded even if en=1. resync has priority over completion. The output buffer and overrun are unaffected.
- ovr_clr=1: clears overrun. If an overrun event occurs on the same edge, set wins.
- en=0: no state change in sreg or bit_cnt. The output handshake still operates.
- out_data changes only on a load, never while FULL without a handshake.

Decomposition:
- Package deser_pkg holds:
  - typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;
  - localparam MAX_WIDTH=64;
  - function cnt_w(width) returning $clog2(width), with a minimum of 1.
- Sub-module deser_bit_cnt (parametrised modulo-WIDTH counter with en and synchronous clear; outputs count and last = (count==WIDTH-1)).
- Shift register and buffer FSM stay in serial_deser.

Test Plan:
- WIDTH=8, LSB_FIRST=1, en=1 continuously, si = bits of 0xA5 LSB first, out_ready=1 -> out_valid=1 and out_data=0xA5 one cycle after the 8th bit; word_done pulses once.
- WIDTH=8, LSB_FIRST=0, si = 1,0,1,1,0,0,1,0 -> out_data=0xB2; en gaps between bits change nothing but timing.
- WIDTH=8, out_ready=0, send 0x3C then 0xFF -> out_data stays 0x3C and overrun=1. ovr_clr -> overrun=0. Then out_ready=1 -> out_valid=0.
- WIDTH=8, FULL with 0x11, second word 0x22 completes on the same edge that out_ready=1 -> out_valid stays 1, out_data=0x22, overrun=0.
- WIDTH=5, send 3 bits, pulse resync, then send 0b10110 LSB first -> out_data=0x16 and bit_cnt wraps 4->0.
- Assert rst with bit_cnt=5 and out_valid=1 -> next cycle all outputs 0; a following full word assembles correctly from bit 0.
